// File: rtl/vram_arb.sv
// Video RAM arbiter: interleaves display fetches with two round-robin requesters on a
// single-port synchronous RAM. Define VRAM_ARB_BLANK_ONLY_EN to restrict requesters to blanking.
module vram_arb #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic              clk25m,
  input  logic              rst_n,
  input  logic [9:0]        hcnt,
  input  logic [9:0]        vcnt,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {SlotNone, SlotDisp, SlotReq0, SlotReq1} slot_e;

  slot_e             slot_q, slot_d;
  logic              ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              active, disp_slot, req_slot;
  logic [1:0]        gnt_c;

  assign active    = (32'(hcnt) < H_ACTIVE) && (32'(vcnt) < V_ACTIVE);
  assign disp_slot = active && !hcnt[0];
`ifdef VRAM_ARB_BLANK_ONLY_EN
  assign req_slot  = !active;
`else
  assign req_slot  = !disp_slot;
`endif

  // ptr_q names the requester that wins a tie
  always_comb begin
    gnt_c = 2'b00;
    if (req_slot) begin
      unique case (req)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = ptr_q ? 2'b10 : 2'b01;
        default: gnt_c = 2'b00;
      endcase
    end
  end

  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = wdata_q;
    gnt       = gnt_c;
    slot_d    = SlotNone;
    ptr_d     = ptr_q;
    if (disp_slot) begin
      ram_addr = disp_addr;
      slot_d   = SlotDisp;
    end else if (gnt_c[0]) begin
      ram_addr  = addr0;
      ram_we    = we[0];
      ram_wdata = wdata0;
      ptr_d     = 1'b1;
      slot_d    = we[0] ? SlotNone : SlotReq0;
    end else if (gnt_c[1]) begin
      ram_addr  = addr1;
      ram_we    = we[1];
      ram_wdata = wdata1;
      ptr_d     = 1'b0;
      slot_d    = we[1] ? SlotNone : SlotReq1;
    end
    // Outputs read as zero for the whole time reset is held, not just after an edge
    if (!rst_n) begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      gnt       = 2'b00;
    end
  end

  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= SlotNone;
      ptr_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      slot_q  <= slot_d;
      ptr_q   <= ptr_d;
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

  assign disp_rvalid = (slot_q == SlotDisp);
  assign disp_rdata  = disp_rvalid ? ram_rdata : '0;
  assign rvalid      = {slot_q == SlotReq1, slot_q == SlotReq0};
  assign rdata       = (|rvalid) ? ram_rdata : '0;

endmodule
